// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_pkg
// Description : Shared constants and FSM state type for the text overlay.
//               Glyph cell geometry, the blank character written by a clear,
//               and the two-state clear/idle controller encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package text_pkg;

    localparam int         CHAR_W      = 8;
    localparam int         CHAR_H      = 16;
    localparam logic [6:0] ASCII_SPACE = 7'h20;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_rom.sv
`default_nettype none
// ============================================================================
// Module      : ascii_rom
// Description : Glyph ROM, 8x16 cells, one registered read per clock.
//               Address = {ascii[6:0], glyph_row[3:0]}; bit 7 of the data is
//               the leftmost pixel. Codes without a stored glyph read blank.
// Ports       : clk    - clock
//               i_addr - 11-bit glyph address
//               o_data - 8-bit glyph row, valid one cycle after i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_rom (
    input  logic        clk,
    input  logic [10:0] i_addr,
    output logic [7:0]  o_data
);

    function automatic logic [7:0] glyph(input logic [10:0] a);
        case (a)
            11'h412: glyph = 8'h10;
            11'h413: glyph = 8'h38;
            11'h414: glyph = 8'h6C;
            11'h415: glyph = 8'hC6;
            11'h416: glyph = 8'hC6;
            11'h417: glyph = 8'hFE;
            11'h418: glyph = 8'hC6;
            11'h419: glyph = 8'hC6;
            11'h41A: glyph = 8'hC6;
            11'h41B: glyph = 8'hC6;
            default: glyph = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        o_data <= glyph(i_addr);
    end

endmodule
`default_nettype wire

// File: rtl/text_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : text_buffer_ram
// Description : Simple dual-port character RAM. One write port, one read port
//               with a registered output. A read and a write to the same
//               address in one cycle return the old contents (read-first).
//               The array itself is not reset.
// Ports       : clk     - clock
//               i_we    - write enable
//               i_waddr - write address
//               i_wdata - write data
//               i_raddr - read address
//               o_rdata - read data, one cycle after i_raddr
// Revision    : 1.0 - initial release
// ============================================================================
module text_buffer_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Both non-blocking: the read samples the array before the write lands.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/text_overlay_display.sv
`default_nettype none
// ============================================================================
// Module      : text_overlay_display
// Description : Runtime-writable COLS x ROWS text overlay rendered as 8x16
//               glyphs at (X0, Y0), with an optional blinking inverse cursor.
//               A clear controller fills the buffer with spaces after reset or
//               on clr_req. Pixel path is 3 cycles from x/y/video_on to rgb,
//               so hsync/vsync must be delayed by 3 to match.
// Ports       : clk, rst_n (async, active-low)
//               video_on, x, y            - from the sync generator
//               wr_valid/wr_ready, wr_col, wr_row, wr_char - buffer write port
//               clr_req                    - start (or restart) a clear
//               cursor_en, cursor_col, cursor_row - cursor cell
//               busy                       - clear in progress
//               rgb                        - registered pixel colour
// Revision    : 1.0 - initial release
// ============================================================================
module text_overlay_display
    import text_pkg::*;
#(
    parameter int          COLS      = 32,
    parameter int          ROWS      = 8,
    parameter int          X0        = 128,
    parameter int          Y0        = 192,
    parameter logic [11:0] FG        = 12'h000,
    parameter logic [11:0] BG        = 12'hFFF,
    parameter int          BLINK_DIV = 12_500_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    video_on,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [6:0]              wr_char,
    input  logic                    clr_req,
    input  logic                    cursor_en,
    input  logic [$clog2(COLS)-1:0] cursor_col,
    input  logic [$clog2(ROWS)-1:0] cursor_row,
    output logic                    busy,
    output logic [11:0]             rgb
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(BLINK_DIV);

    localparam logic [9:0] c_X0    = 10'(X0);
    localparam logic [9:0] c_X_END = 10'(X0 + COLS * CHAR_W);
    localparam logic [9:0] c_Y0    = 10'(Y0);
    localparam logic [9:0] c_Y_END = 10'(Y0 + ROWS * CHAR_H);

    // ------------------------------------------------------------------
    // Clear controller
    // ------------------------------------------------------------------
    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_clr_addr, w_clr_addr_nxt;
    logic            w_wr_fire;
    logic            w_wr_in_range;
    logic            w_ram_we;
    logic [AW-1:0]   w_ram_waddr;
    logic [6:0]      w_ram_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            CLEAR: begin
                if (clr_req) begin
                    w_clr_addr_nxt = '0;
                end else if (r_clr_addr == AW'(DEPTH - 1)) begin
                    w_state_nxt    = IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt    = CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    // Out-of-range coordinates still complete the handshake; they just
    // never reach the RAM (otherwise they would alias onto another cell).
    assign w_wr_fire     = wr_valid && (r_state == IDLE);
    assign w_wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);

    always_comb begin
        wr_ready    = (r_state == IDLE);
        busy        = (r_state == CLEAR);
        w_ram_we    = 1'b0;
        w_ram_waddr = r_clr_addr;
        w_ram_wdata = ASCII_SPACE;
        if (r_state == CLEAR) begin
            w_ram_we = 1'b1;
        end else if (w_wr_fire && w_wr_in_range) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
            w_ram_wdata = wr_char;
        end
    end

    // ------------------------------------------------------------------
    // Cursor blink timebase (free-running in both controller states)
    // ------------------------------------------------------------------
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: region / cell decode, buffer read address
    // ------------------------------------------------------------------
    logic [9:0]    w_dx, w_dy;
    logic          w_in_region;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [AW-1:0] w_rd_addr;
    logic          w_cur_hit;

    assign w_dx        = x - c_X0;
    assign w_dy        = y - c_Y0;
    assign w_in_region = (x >= c_X0) && (x < c_X_END) && (y >= c_Y0) && (y < c_Y_END);
    assign w_col       = CW'(w_dx >> 3);
    assign w_row       = RW'(w_dy >> 4);
    // Parked at 0 outside the region so the RAM is never indexed past DEPTH.
    assign w_rd_addr   = w_in_region ? (AW'(w_row) * AW'(COLS) + AW'(w_col)) : '0;
    assign w_cur_hit   = cursor_en && r_blink_phase &&
                         (w_col == cursor_col) && (w_row == cursor_row);

    // ------------------------------------------------------------------
    // Stage 1: buffer data available, ROM address formed
    // ------------------------------------------------------------------
    logic       r_s1_vid, r_s1_in, r_s1_cur;
    logic [3:0] r_s1_grow;
    logic [2:0] r_s1_bit;
    logic [6:0] w_char;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vid  <= 1'b0;
            r_s1_in   <= 1'b0;
            r_s1_cur  <= 1'b0;
            r_s1_grow <= '0;
            r_s1_bit  <= '0;
        end else begin
            r_s1_vid  <= video_on;
            r_s1_in   <= w_in_region;
            r_s1_cur  <= w_cur_hit;
            r_s1_grow <= w_dy[3:0];
            r_s1_bit  <= w_dx[2:0];
        end
    end

    text_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (7)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_char)
    );

    // ------------------------------------------------------------------
    // Stage 2: ROM data, bit select, colour register
    // ------------------------------------------------------------------
    logic       r_s2_vid, r_s2_in, r_s2_cur;
    logic [2:0] r_s2_bit;
    logic [7:0] w_rom_data;
    logic       w_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vid <= 1'b0;
            r_s2_in  <= 1'b0;
            r_s2_cur <= 1'b0;
            r_s2_bit <= '0;
        end else begin
            r_s2_vid <= r_s1_vid;
            r_s2_in  <= r_s1_in;
            r_s2_cur <= r_s1_cur;
            r_s2_bit <= r_s1_bit;
        end
    end

    ascii_rom u_rom (
        .clk    (clk),
        .i_addr ({w_char, r_s1_grow}),
        .o_data (w_rom_data)
    );

    // Bit 7 of a glyph row is the leftmost pixel.
    assign w_pix = w_rom_data[3'd7 - r_s2_bit];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= 12'h000;
        end else if (!r_s2_vid) begin
            rgb <= 12'h000;
        end else if (r_s2_in && (w_pix ^ r_s2_cur)) begin
            rgb <= FG;
        end else begin
            rgb <= BG;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_overlay_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_overlay_display
// Description : Self-checking bench for text_overlay_display with a small
//               5x3 buffer, table-driven pixel vectors and directed sequences
//               for clear timing, restart, cursor blink and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_overlay_display;

    localparam int          COLS      = 5;
    localparam int          ROWS      = 3;
    localparam int          X0        = 24;
    localparam int          Y0        = 16;
    localparam int          BLINK_DIV = 4;
    localparam int          DEPTH     = COLS * ROWS;
    localparam int          NPIX      = COLS * 8 * ROWS * 16;
    localparam logic [11:0] FG        = 12'h0A5;
    localparam logic [11:0] BG        = 12'hFFF;

    logic        clk, rst_n, video_on;
    logic [9:0]  x, y;
    logic        wr_valid, wr_ready;
    logic [2:0]  wr_col, cursor_col;
    logic [1:0]  wr_row, cursor_row;
    logic [6:0]  wr_char;
    logic        clr_req, cursor_en, busy;
    logic [11:0] rgb;

    int total = 0;
    int bad   = 0;
    int cyc;

    text_overlay_display #(
        .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0),
        .FG(FG), .BG(BG), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col),
        .wr_row(wr_row), .wr_char(wr_char), .clr_req(clr_req),
        .cursor_en(cursor_en), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .busy(busy), .rgb(rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release; used by the blink model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        int          px;
        int          py;
        logic        vid;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs[18];
    logic [11:0] row5[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int px, input int py, input logic v);
        x        = 10'(px);
        y        = 10'(py);
        video_on = v;
    endtask

    task automatic pix(input string name, input int px, input int py, input logic [11:0] exp);
        set_pix(px, py, 1'b1);
        repeat (3) tick();
        check(name, 32'(rgb), 32'(exp));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!wr_ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic do_write(input int c, input int r, input logic [6:0] ch);
        int n;
        wr_col   = 3'(c);
        wr_row   = 2'(r);
        wr_char  = ch;
        wr_valid = 1'b1;
        wait_ready(n);
        check("write_handshake", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    // Streams every region pixel and counts non-background results.
    task automatic scan_region(output int nbad);
        nbad = 0;
        for (int i = 0; i < NPIX + 2; i++) begin
            if (i < NPIX) set_pix(X0 + i % (COLS * 8), Y0 + i / (COLS * 8), 1'b1);
            tick();
            if (i >= 2 && rgb !== BG) nbad++;
        end
    endtask

    initial begin
        int n, nb, acc;
        logic [11:0] exp;

        vecs[0]  = '{32, 21, 1'b1, FG};
        vecs[1]  = '{33, 21, 1'b1, FG};
        vecs[2]  = '{34, 21, 1'b1, BG};
        vecs[3]  = '{35, 21, 1'b1, BG};
        vecs[4]  = '{36, 21, 1'b1, BG};
        vecs[5]  = '{37, 21, 1'b1, FG};
        vecs[6]  = '{38, 21, 1'b1, FG};
        vecs[7]  = '{39, 21, 1'b1, BG};
        vecs[8]  = '{32, 16, 1'b1, BG};
        vecs[9]  = '{39, 23, 1'b1, BG};
        vecs[10] = '{32, 23, 1'b1, FG};
        vecs[11] = '{23, 21, 1'b1, BG};
        vecs[12] = '{64, 21, 1'b1, BG};
        vecs[13] = '{40, 21, 1'b1, BG};
        vecs[14] = '{32, 15, 1'b1, BG};
        vecs[15] = '{32, 64, 1'b1, BG};
        vecs[16] = '{32, 21, 1'b0, 12'h000};
        vecs[17] = '{500, 400, 1'b0, 12'h000};
        row5 = '{FG, FG, BG, BG, BG, FG, FG, BG};

        rst_n = 1'b0; video_on = 1'b0; x = '0; y = '0;
        wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0;
        clr_req = 1'b0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;

        // Reset state and clear duration
        repeat (3) tick();
        check("rst_rgb", 32'(rgb), 32'h000);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        wait_ready(n);
        check("reset_clear_cycles", 32'(n), 32'(DEPTH));
        check("busy_after_clear", 32'(busy), 32'd0);
        scan_region(nb);
        check("scan_spaces", 32'(nb), 32'd0);

        // Single write and table-driven pixel vectors
        do_write(1, 0, 7'h41);
        for (int i = 0; i < 18; i++) begin
            set_pix(vecs[i].px, vecs[i].py, vecs[i].vid);
            repeat (3) tick();
            check($sformatf("vec%0d", i), 32'(rgb), 32'(vecs[i].exp));
        end

        // One pixel per clock: verifies exact 3-cycle latency
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_pix(32 + i, 21, 1'b1);
            tick();
            if (i >= 2) check($sformatf("stream%0d", i - 2), 32'(rgb), 32'(row5[i-2]));
        end

        // Back-to-back writes, two of them out of range
        acc = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin wr_col = 3'd0; wr_row = 2'd2; end
                1: begin wr_col = 3'd5; wr_row = 2'd0; end
                2: begin wr_col = 3'd7; wr_row = 2'd1; end
                default: begin wr_col = 3'd3; wr_row = 2'd2; end
            endcase
            wr_char = 7'h41;
            if (wr_ready) acc++;
            tick();
        end
        wr_valid = 1'b0;
        check("b2b_accepted", 32'(acc), 32'd4);
        pix("cell_0_2", 24, 53, FG);
        pix("cell_3_2", 48, 53, FG);
        pix("alias_0_1", 24, 37, BG);
        pix("alias_2_2", 40, 53, BG);

        // Clear with a same-cycle write, then restart at address 3
        clr_req = 1'b1; wr_valid = 1'b1;
        wr_col = 3'd4; wr_row = 2'd0; wr_char = 7'h41;
        tick();
        clr_req = 1'b0; wr_valid = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_not_ready", 32'(wr_ready), 32'd0);
        repeat (3) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wait_ready(n);
        check("clr_restart_cycles", 32'(n), 32'(DEPTH));
        scan_region(nb);
        check("scan_after_clear", 32'(nb), 32'd0);

        // Asynchronous reset while rgb shows FG
        do_write(1, 0, 7'h41);
        pix("pre_reset_fg", 32, 21, FG);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rgb", 32'(rgb), 32'h000);
        check("async_ready", 32'(wr_ready), 32'd0);
        check("async_busy", 32'(busy), 32'd1);
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("post_reset_clear_cycles", 32'(n), 32'(DEPTH));

        // Cursor blink on a space cell: phase after edge m is (m/4)%2,
        // and rgb after edge n reflects the phase after edge n-3.
        cursor_en = 1'b1; cursor_col = 3'd4; cursor_row = 2'd2;
        set_pix(59, 60, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < 16; i++) begin
            exp = (((cyc - 3) / BLINK_DIV) % 2 == 1) ? FG : BG;
            check($sformatf("blink%0d", i), 32'(rgb), 32'(exp));
            tick();
        end
        cursor_en = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("cursor_off%0d", i), 32'(rgb), 32'(BG));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
